// File: rtl/ddr_pattern_checker_if.sv
// Request/response bus between the pattern checker and the Avalon-MM DDR request adapter.
// Level-style requests (wr_rq/rd_rq held until action_done); no added latency.
// Backpressure: the adapter stalls a request simply by delaying its action_done pulse.
//
// Ports (master = checker side):
//   wr_rq, rd_rq        request levels
//   wr_adr, rd_adr      word address, stable for the whole request
//   wr_data             write data, stable for the whole request
//   byte_enable         constant all ones
//   action_done         single-cycle completion pulse from the adapter
//   rd_data             read data, valid only with action_done during a read
interface ddr_pattern_checker_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 256
);
  logic              wr_rq;
  logic              rd_rq;
  logic [ADDR_W-1:0] wr_adr;
  logic [ADDR_W-1:0] rd_adr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W/8-1:0] byte_enable;
  logic              action_done;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output wr_rq, rd_rq, wr_adr, rd_adr, wr_data, byte_enable,
    input  action_done, rd_data
  );

  modport slave (
    input  wr_rq, rd_rq, wr_adr, rd_adr, wr_data, byte_enable,
    output action_done, rd_data
  );
endinterface

// File: rtl/ddr_pattern_checker.sv
// DDR pattern checker: writes a deterministic pattern over a word range, reads it back, compares.
// Latency: request rises 1 cycle after start; per word = adapter latency + 1 + GAP_CYCLES.
// Backpressure: each request is held until action_done; a request held TIMEOUT_CYCLES aborts the test.
//
// Ports:
//   RST_I, CLK_I     asynchronous active-high reset, clock
//   start            single-cycle start pulse (ignored while busy)
//   busy, done       test running / finished (done held until next start)
//   pass             valid with done: no mismatch and no timeout
//   timeout          a request was not completed in time
//   err_count        saturating mismatch count
//   first_err_adr    address of the first mismatching word
//   bus              request interface towards the DDR adapter (master side)
//
// Optional build macro DDR_CHK_LFSR_EN: replaces the incrementing pattern with a
// 32-bit Galois LFSR (x^32+x^22+x^2+x+1), lane i = LFSR ^ i.
module ddr_pattern_checker #(
  parameter int          ADDR_W         = 25,
  parameter int          DATA_W         = 256,
  parameter int unsigned START_ADDR     = 0,
  parameter int unsigned NUM_WORDS      = 1024,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [31:0] PATTERN_BASE   = 32'hA5A5_0000
) (
  input  logic              RST_I,
  input  logic              CLK_I,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_adr,
  ddr_pattern_checker_if.master bus
);

  localparam int LANES = DATA_W / 32;
  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);

`ifdef DDR_CHK_LFSR_EN
  // A zero seed would lock the LFSR at zero forever.
  localparam logic [31:0] SEED = (PATTERN_BASE == 32'h0) ? 32'h1 : PATTERN_BASE;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] next_pat(input logic [31:0] p);
    return {1'b0, p[31:1]} ^ (p[0] ? LFSR_TAPS : 32'h0);
  endfunction
`else
  localparam logic [31:0] SEED = PATTERN_BASE;

  function automatic logic [31:0] next_pat(input logic [31:0] p);
    return p + 32'd1;
  endfunction
`endif

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, FIN} state_t;

  state_t            state;
  logic [31:0]       k;       // word index within the pass
  logic [31:0]       cnt;     // gap counter or request-wait counter, depending on state
  logic [ADDR_W-1:0] adr;     // START_ADDR + k, wrapping at 2^ADDR_W
  logic [31:0]       pat;     // 32-bit pattern word for index k
  logic              wr_rq_q;
  logic              rd_rq_q;
  logic [DATA_W-1:0] word;    // full-width expected/written word
  logic              last_k;

  assign last_k = (k == NUM_WORDS - 1);

  always_comb begin
    word = '0;
    for (int i = 0; i < LANES; i++) begin
`ifdef DDR_CHK_LFSR_EN
      word[i*32 +: 32] = pat ^ 32'(i);
`else
      word[i*32 +: 32] = pat;
`endif
    end
  end

  assign bus.wr_rq       = wr_rq_q;
  assign bus.rd_rq       = rd_rq_q;
  assign bus.wr_adr      = adr;
  assign bus.rd_adr      = adr;
  // Gated so the data bus is quiet outside a test, whatever the pattern generator holds.
  assign bus.wr_data     = busy ? word : '0;
  assign bus.byte_enable = '1;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state         <= IDLE;
      k             <= '0;
      cnt           <= '0;
      adr           <= '0;
      pat           <= '0;
      wr_rq_q       <= 1'b0;
      rd_rq_q       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      err_count     <= '0;
      first_err_adr <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            state         <= WR_REQ;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_count     <= '0;
            first_err_adr <= '0;
            k             <= '0;
            adr           <= START_A;
            pat           <= SEED;
            cnt           <= '0;
            wr_rq_q       <= 1'b1;
          end
        end

        WR_REQ: begin
          // action_done takes priority over a simultaneous expiry.
          if (bus.action_done) begin
            wr_rq_q <= 1'b0;
            cnt     <= '0;
            state   <= WR_GAP;
          end else if (cnt == TIMEOUT_CYCLES - 1) begin
            wr_rq_q <= 1'b0;
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
            state   <= FIN;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        WR_GAP: begin
          if (cnt == GAP_CYCLES - 1) begin
            cnt <= '0;
            if (last_k) begin
              // Read phase restarts the generator so expected words line up.
              k       <= '0;
              adr     <= START_A;
              pat     <= SEED;
              rd_rq_q <= 1'b1;
              state   <= RD_REQ;
            end else begin
              k       <= k + 32'd1;
              adr     <= adr + ADDR_W'(1);
              pat     <= next_pat(pat);
              wr_rq_q <= 1'b1;
              state   <= WR_REQ;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        RD_REQ: begin
          if (bus.action_done) begin
            if (bus.rd_data != word) begin
              if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
              // err_count never returns to zero within a pass, so this marks the first miss.
              if (err_count == 16'd0) first_err_adr <= adr;
            end
            rd_rq_q <= 1'b0;
            cnt     <= '0;
            state   <= RD_GAP;
          end else if (cnt == TIMEOUT_CYCLES - 1) begin
            rd_rq_q <= 1'b0;
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
            state   <= FIN;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        RD_GAP: begin
          if (cnt == GAP_CYCLES - 1) begin
            cnt <= '0;
            if (last_k) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == 16'd0) && !timeout;
              state <= FIN;
            end else begin
              k       <= k + 32'd1;
              adr     <= adr + ADDR_W'(1);
              pat     <= next_pat(pat);
              rd_rq_q <= 1'b1;
              state   <= RD_REQ;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_pattern_checker.sv
module tb_ddr_pattern_checker;
  localparam int          ADDR_W = 25;
  localparam int          DATA_W = 256;
  localparam int unsigned SA     = 32'h1FF_FFFE;
  localparam int unsigned NW     = 8;
  localparam int unsigned GAP    = 4;
  localparam int unsigned TO     = 64;
  localparam logic [31:0] PB     = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy, done, pass, timeout;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] first_err_adr;

  ddr_pattern_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ddr_pattern_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .START_ADDR(SA), .NUM_WORDS(NW),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .PATTERN_BASE(PB)
  ) dut (
    .RST_I(rst), .CLK_I(clk), .start(start), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .err_count(err_count),
    .first_err_adr(first_err_adr), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // DDR model knobs and observation logs
  bit                corrupt_en  = 1'b0;
  logic [ADDR_W-1:0] corrupt_adr = '0;
  bit                zero_mode   = 1'b0;
  bit                spur_en     = 1'b0;
  int                hang_idx    = -1;
  int                slow_idx    = -1;
  int                slow_lat    = 0;
  int                wr_num      = 0;
  int                held_last   = 0;
  int                stab_err    = 0;
  logic [ADDR_W-1:0] wr_log[$];
  logic [ADDR_W-1:0] rd_log[$];
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

  // Reference rules: address k = START_ADDR + k mod 2^ADDR_W, word k = {8{PATTERN_BASE + k}}
  function automatic logic [ADDR_W-1:0] ref_adr(int k);
    return ADDR_W'(SA + 32'(k));
  endfunction

  function automatic logic [DATA_W-1:0] ref_word(int k);
    return {8{PB + 32'(k)}};
  endfunction

  function automatic logic [DATA_W-1:0] model_read(logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    d = '0;
    if (!zero_mode && mem.exists(a)) d = mem[a];
    if (corrupt_en && a == corrupt_adr) d[0] = ~d[0];
    return d;
  endfunction

  // Expected result of an uninterrupted pass given the current model knobs.
  task automatic ref_result(output int e, output logic [ADDR_W-1:0] f);
    logic [DATA_W-1:0] got;
    e = 0;
    f = '0;
    for (int k = 0; k < int'(NW); k++) begin
      got = zero_mode ? '0 : ref_word(k);
      if (corrupt_en && ref_adr(k) == corrupt_adr) got[0] = ~got[0];
      if (got != ref_word(k)) begin
        if (e == 0) f = ref_adr(k);
        e++;
      end
    end
    if (e > 65535) e = 65535;
  endtask

  // Ideal DDR: action_done a few cycles after each request rise, memory echoes writes.
  initial begin : ddr_model
    int pend, wait_cnt, held;
    logic pw, pr;
    logic [ADDR_W-1:0] h_adr;
    logic [DATA_W-1:0] h_dat;
    pend = 0; wait_cnt = 0; held = 0; pw = 1'b0; pr = 1'b0;
    h_adr = '0; h_dat = '0;
    bus.action_done = 1'b0;
    bus.rd_data = '0;
    forever begin
      @(negedge clk);
      bus.action_done = 1'b0;
      bus.rd_data = {8{$urandom}};
      if (rst) begin
        pend = 0; pw = 1'b0; pr = 1'b0;
        continue;
      end
      if ((pend == 1 && !bus.wr_rq) || (pend == 2 && !bus.rd_rq)) begin
        held_last = held;
        pend = 0;
      end else if (pend != 0) begin
        held++;
        if ((pend == 1 && (bus.wr_adr !== h_adr || bus.wr_data !== h_dat)) ||
            (pend == 2 && bus.rd_adr !== h_adr)) stab_err++;
        if (wait_cnt > 0) begin
          wait_cnt--;
          if (wait_cnt == 0) begin
            if (pend == 1) mem[h_adr] = h_dat;
            else bus.rd_data = model_read(h_adr);
            bus.action_done = 1'b1;
            held_last = held;
            pend = 0;
          end
        end
      end else if (bus.wr_rq && !pw) begin
        pend = 1; held = 1;
        h_adr = bus.wr_adr; h_dat = bus.wr_data;
        wr_log.push_back(h_adr);
        if (wr_num == hang_idx) wait_cnt = 0;
        else if (wr_num == slow_idx) wait_cnt = slow_lat;
        else wait_cnt = $urandom_range(1, 5);
        wr_num++;
      end else if (bus.rd_rq && !pr) begin
        pend = 2; held = 1;
        h_adr = bus.rd_adr;
        rd_log.push_back(h_adr);
        wait_cnt = $urandom_range(1, 5);
      end else if (spur_en && !bus.wr_rq && !bus.rd_rq && $urandom_range(0, 3) == 0) begin
        bus.action_done = 1'b1;
      end
      pw = bus.wr_rq;
      pr = bus.rd_rq;
    end
  end

  task automatic start_pulse();
    wr_log.delete(); rd_log.delete();
    wr_num = 0; stab_err = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(output bit fin);
    fin = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (done) begin fin = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag);
    int e;
    logic [ADDR_W-1:0] f;
    ref_result(e, f);
    n_cmp++;
    if (err_count !== 16'(e)) begin
      n_bad++; $display("FAIL %s err_count: got %0d want %0d", tag, err_count, e);
    end
    n_cmp++;
    if (e != 0 && first_err_adr !== f) begin
      n_bad++; $display("FAIL %s first_err_adr: got %0h want %0h", tag, first_err_adr, f);
    end
    n_cmp++;
    if ({busy, done, timeout, pass} !== {1'b0, 1'b1, 1'b0, e == 0}) begin
      n_bad++; $display("FAIL %s busy/done/timeout/pass: got %b want %b", tag,
                        {busy, done, timeout, pass}, {1'b0, 1'b1, 1'b0, e == 0});
    end
  endtask

  task automatic check_logs(input string tag);
    n_cmp++;
    if (wr_log.size() != int'(NW) || rd_log.size() != int'(NW)) begin
      n_bad++; $display("FAIL %s log sizes: got %0d/%0d want %0d", tag, wr_log.size(), rd_log.size(), NW);
    end
    for (int k = 0; k < int'(NW) && k < wr_log.size() && k < rd_log.size(); k++) begin
      n_cmp++;
      if (wr_log[k] !== ref_adr(k) || rd_log[k] !== ref_adr(k)) begin
        n_bad++; $display("FAIL %s adr[%0d]: got wr %0h rd %0h want %0h", tag, k, wr_log[k], rd_log[k], ref_adr(k));
      end
    end
    n_cmp++;
    if (stab_err != 0) begin
      n_bad++; $display("FAIL %s request stability: got %0d changes want 0", tag, stab_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, pass, timeout, err_count, first_err_adr} !== '0) begin
      n_bad++; $display("FAIL reset_status: got %b %b %b %b %0h %0h want all 0",
                        busy, done, pass, timeout, err_count, first_err_adr);
    end
    n_cmp++;
    if ({bus.wr_rq, bus.rd_rq, bus.wr_adr, bus.rd_adr, bus.wr_data} !== '0) begin
      n_bad++; $display("FAIL reset_bus: got rq %b%b adr %0h/%0h data %0h want 0",
                        bus.wr_rq, bus.rd_rq, bus.wr_adr, bus.rd_adr, bus.wr_data);
    end
    n_cmp++;
    if (bus.byte_enable !== {(DATA_W/8){1'b1}}) begin
      n_bad++; $display("FAIL reset_byte_enable: got %0h want all ones", bus.byte_enable);
    end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit fin;
    spur_en = 1'b1;
    start_pulse();
    n_cmp++;
    if (bus.wr_rq !== 1'b1 || busy !== 1'b1 || bus.wr_adr !== ref_adr(0)) begin
      n_bad++; $display("FAIL basic_first_request: got wr_rq %b busy %b adr %0h want 1 1 %0h",
                        bus.wr_rq, busy, bus.wr_adr, ref_adr(0));
    end
    wait_done(fin);
    n_cmp++;
    if (!fin) begin n_bad++; $display("FAIL basic_done: got no done want done within bound"); end
    check_result("basic");
    check_logs("basic");
    for (int k = 0; k < int'(NW); k++) begin
      n_cmp++;
      if (!mem.exists(ref_adr(k)) || mem[ref_adr(k)] !== ref_word(k)) begin
        n_bad++; $display("FAIL basic_mem[%0d]: got %0h want %0h", k,
                          mem.exists(ref_adr(k)) ? mem[ref_adr(k)] : '0, ref_word(k));
      end
    end
    spur_en = 1'b0;
  endtask

  task automatic test_corrupt();
    bit fin;
    for (int it = 0; it < 3; it++) begin
      corrupt_en = 1'b1;
      corrupt_adr = ref_adr(it == 0 ? 5 : int'($urandom_range(0, NW - 1)));
      start_pulse();
      wait_done(fin);
      n_cmp++;
      if (!fin) begin n_bad++; $display("FAIL corrupt_done: got no done want done within bound"); end
      check_result("corrupt");
    end
    corrupt_en = 1'b0;
  endtask

  task automatic test_zero();
    bit fin;
    zero_mode = 1'b1;
    start_pulse();
    wait_done(fin);
    n_cmp++;
    if (!fin) begin n_bad++; $display("FAIL zero_done: got no done want done within bound"); end
    check_result("zero");
    n_cmp++;
    if (err_count !== 16'(NW) || first_err_adr !== ADDR_W'(SA)) begin
      n_bad++; $display("FAIL zero_all_words: got %0d @%0h want %0d @%0h", err_count, first_err_adr, NW, SA);
    end
    zero_mode = 1'b0;
  endtask

  task automatic test_timeout();
    bit fin;
    hang_idx = 2;
    start_pulse();
    wait_done(fin);
    hang_idx = -1;
    repeat (50) @(negedge clk);
    n_cmp++;
    if (!fin || held_last != int'(TO)) begin
      n_bad++; $display("FAIL timeout_hold: got done %b held %0d want done 1 held %0d", fin, held_last, TO);
    end
    n_cmp++;
    if ({timeout, done, pass, busy} !== 4'b1100) begin
      n_bad++; $display("FAIL timeout_status: got t/d/p/b %b want 1100", {timeout, done, pass, busy});
    end
    n_cmp++;
    if (wr_log.size() != 3 || rd_log.size() != 0) begin
      n_bad++; $display("FAIL timeout_requests: got wr %0d rd %0d want 3 0", wr_log.size(), rd_log.size());
    end
  endtask

  task automatic test_timeout_edge();
    bit fin;
    // Completion sampled on the expiry cycle itself must win.
    slow_idx = 1; slow_lat = int'(TO) - 1;
    start_pulse();
    wait_done(fin);
    n_cmp++;
    if (!fin || {timeout, pass} !== 2'b01 || wr_log.size() != int'(NW)) begin
      n_bad++; $display("FAIL timeout_edge_in_time: got done %b t/p %b writes %0d want 1 01 %0d",
                        fin, {timeout, pass}, wr_log.size(), NW);
    end
    slow_lat = int'(TO);
    start_pulse();
    wait_done(fin);
    n_cmp++;
    if (!fin || {timeout, pass} !== 2'b10 || wr_log.size() != 2 || held_last != int'(TO)) begin
      n_bad++; $display("FAIL timeout_edge_late: got done %b t/p %b writes %0d held %0d want 1 10 2 %0d",
                        fin, {timeout, pass}, wr_log.size(), held_last, TO);
    end
    slow_idx = -1;
  endtask

  task automatic test_reset_midrun();
    bit fin, seen;
    corrupt_en = 1'b1; corrupt_adr = ref_adr(0);
    start_pulse();
    seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (bus.rd_rq && rd_log.size() == 2) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++;
    if (!seen || err_count !== 16'd1) begin
      n_bad++; $display("FAIL reset_mid_reach: got rd_rq seen %b err %0d want 1 1", seen, err_count);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.rd_rq, bus.wr_rq, busy, done, pass, timeout, err_count, first_err_adr} !== '0) begin
      n_bad++; $display("FAIL reset_mid_clear: got rq %b%b b/d/p/t %b err %0d adr %0h want all 0",
                        bus.rd_rq, bus.wr_rq, {busy, done, pass, timeout}, err_count, first_err_adr);
    end
    corrupt_en = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    start_pulse();
    wait_done(fin);
    n_cmp++;
    if (!fin) begin n_bad++; $display("FAIL reset_mid_rerun_done: got no done want done within bound"); end
    check_result("reset_rerun");
    check_logs("reset_rerun");
  endtask

  task automatic test_start_ignored();
    bit fin;
    start_pulse();
    fin = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (done) begin fin = 1'b1; break; end
      if (busy && $urandom_range(0, 15) == 0) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n_cmp++;
    if (!fin) begin n_bad++; $display("FAIL busy_start_done: got no done want done within bound"); end
    check_result("busy_start");
    check_logs("busy_start");
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no completion want summary before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_corrupt();
    test_zero();
    test_timeout();
    test_timeout_edge();
    test_reset_midrun();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
